// File: rtl/vx_dcache_rsp_pkg.sv
// Shared helpers for the dcache responder: lane-index width rule and response
// entry layout used by the response FIFO.
package vx_dcache_rsp_pkg;

  // An index for n items needs clog2(n) bits, but never fewer than one.
  function automatic int lane_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Field widths of the response entry in the default configuration.
  localparam int RSP_LANE_W = 2;
  localparam int RSP_TAG_W  = 8;
  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic [RSP_LANE_W-1:0] lane;
    logic [RSP_TAG_W-1:0]  tag;
    logic [RSP_DATA_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/vx_dcache_responder_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past the winner when enable is high.
module vx_rr_arbiter
  import vx_dcache_rsp_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int LANE_W = lane_width(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output logic [LANE_W-1:0]   grant_index,
  output logic                grant_valid
);

  logic [LANE_W-1:0] ptr_q;

  always_comb begin
    int                idx;
    logic [LANE_W-1:0] idx_l;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_l       = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      idx_l = LANE_W'(idx);
      if (!grant_valid && requests[idx_l]) begin
        grant_valid  = 1'b1;
        grant[idx_l] = 1'b1;
        grant_index  = idx_l;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (enable && grant_valid) begin
      ptr_q <= (grant_index == LANE_W'(NUM_REQS - 1)) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/vx_dcache_responder.sv
// Per-lane dcache request slave: arbitrates lanes into a single-ported word
// memory and returns read data through a credit-protected response FIFO.
module vx_dcache_responder
  import vx_dcache_rsp_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 2,
  localparam int LANE_W = lane_width(NUM_REQS),
  localparam int DATA_W = 8 * WORD_SIZE
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS-1:0]            req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]  req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQS*DATA_W-1:0]     req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           rsp_valid,
  output logic [LANE_W-1:0]              rsp_lane,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic                           rsp_ready
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int FPTR_W = lane_width(RSP_DEPTH);

  typedef struct packed {
    logic [LANE_W-1:0]    lane;
    logic [TAG_WIDTH-1:0] tag;
    logic [DATA_W-1:0]    data;
  } entry_t;

  function automatic logic [FPTR_W-1:0] fifo_next(input logic [FPTR_W-1:0] p);
    return (p == FPTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CNT_W-1:0]      credits;
  logic [NUM_REQS-1:0]   eligible;
  logic [NUM_REQS-1:0]   grant;
  logic [LANE_W-1:0]     sel;
  logic                  acc, acc_rd, acc_wr;
  logic                  sel_rw;
  logic [WORD_SIZE-1:0]  sel_byteen;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_data;
  logic [TAG_WIDTH-1:0]  sel_tag;

  // Reads need a free response slot; writes never produce a response.
  assign eligible = req_valid & (req_rw | {NUM_REQS{credits != '0}}) & {NUM_REQS{reset_n}};

  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .requests    (eligible),
    .enable      (acc),
    .grant       (grant),
    .grant_index (sel),
    .grant_valid (acc)
  );

  assign req_ready = grant;
  assign acc_rd    = acc && !sel_rw;
  assign acc_wr    = acc && sel_rw;

  always_comb begin
    sel_rw     = 1'b0;
    sel_byteen = '0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_tag    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (sel == LANE_W'(i)) begin
        sel_rw     = req_rw[i];
        sel_byteen = req_byteen[i*WORD_SIZE +: WORD_SIZE];
        sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = req_data[i*DATA_W +: DATA_W];
        sel_tag    = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Stage p0 -> p1: memory access at the accepting edge
  logic [WORD_SIZE-1:0][7:0] mem [DEPTH];
  logic [DATA_W-1:0]         rd_data_p1;
  logic [LANE_W-1:0]         lane_p1;
  logic [TAG_WIDTH-1:0]      tag_p1;
  logic                      vld_p1;

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int b = 0; b < WORD_SIZE; b++) begin
        if (sel_byteen[b]) mem[sel_addr][b] <= sel_data[8*b +: 8];
      end
    end
    if (acc_rd) begin
      rd_data_p1 <= mem[sel_addr];
      lane_p1    <= sel;
      tag_p1     <= sel_tag;
    end
  end

  // Stage p1 -> FIFO: push the completed read
  entry_t             fifo_q [RSP_DEPTH];
  logic [FPTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;
  entry_t             head;

  assign push = vld_p1;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{lane: lane_p1, tag: tag_p1, data: rd_data_p1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CNT_W'(RSP_DEPTH);
    end else begin
      vld_p1 <= acc_rd;
      if (push) wr_ptr <= fifo_next(wr_ptr);
      if (pop)  rd_ptr <= fifo_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case ({acc_rd, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  assign head      = fifo_q[rd_ptr];
  assign rsp_valid = (count != '0);
  assign rsp_lane  = rsp_valid ? head.lane : '0;
  assign rsp_tag   = rsp_valid ? head.tag  : '0;
  assign rsp_data  = rsp_valid ? head.data : '0;

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Randomized and directed bench for vx_dcache_responder with a queue-based
// behavioural model checked every cycle.
module tb_vx_dcache_responder;
  localparam int N = 4, WS = 4, TW = 8, AW = 10, RD = 2, DW = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req_valid, req_rw, req_ready;
  logic [N*WS-1:0] req_byteen;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_lane;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_tag;

  vx_dcache_responder #(
    .NUM_REQS(N), .WORD_SIZE(WS), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outstanding reads in acceptance order, each visible from cycle avail.
  typedef struct {
    int          lane;
    logic [7:0]  tag;
    logic [31:0] data;
    int          avail;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] mmem [int];
  int          mptr = 0;
  int          cyc  = 0;

  always @(negedge clk) begin : cmp
    int          credits, gi, a;
    logic [N-1:0] eg;
    logic        ev;
    logic [31:0] w;
    exp_t        e;
    if (!reset_n) begin
      mq.delete();
      mptr = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_lane", rsp_lane, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
    end else begin
      credits = RD - mq.size();
      gi = -1;
      eg = '0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (gi < 0 && req_valid[i] && (req_rw[i] || credits > 0)) gi = i;
      end
      if (gi >= 0) eg[gi] = 1'b1;
      chk("req_ready", req_ready, eg);
      ev = (mq.size() > 0) && (mq[0].avail <= cyc);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_lane", rsp_lane, mq[0].lane);
        chk("rsp_tag", rsp_tag, mq[0].tag);
        chk("rsp_data", rsp_data, mq[0].data);
        if (rsp_ready) void'(mq.pop_front());
      end else begin
        chk("idle_rsp_data", rsp_data, 0);
        chk("idle_rsp_tag", rsp_tag, 0);
      end
      if (gi >= 0) begin
        mptr = (gi + 1) % N;
        a = int'(req_addr[gi*AW +: AW]);
        if (req_rw[gi]) begin
          w = mmem.exists(a) ? mmem[a] : 32'h0;
          for (int b = 0; b < WS; b++)
            if (req_byteen[gi*WS + b]) w[8*b +: 8] = req_data[gi*DW + 8*b +: 8];
          mmem[a] = w;
        end else begin
          e.lane  = gi;
          e.tag   = req_tag[gi*TW +: TW];
          e.data  = mmem.exists(a) ? mmem[a] : 32'h0;
          e.avail = cyc + 2;
          mq.push_back(e);
        end
      end
    end
    cyc++;
  end

  task automatic idle();
    req_valid = '0; req_rw = '0; req_byteen = '0;
    req_addr = '0; req_data = '0; req_tag = '0;
  endtask

  task automatic set_lane(input int i, input logic rw, input logic [3:0] be,
                          input logic [9:0] a, input logic [31:0] d, input logic [7:0] t);
    req_valid[i] = 1'b1;
    req_rw[i] = rw;
    req_byteen[i*WS +: WS] = be;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_tag[i*TW +: TW] = t;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int acc, wcnt, n, g;
    int order [4];
    logic [N-1:0] gr, pending;
    idle();
    rsp_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Preload a small address window so every read has a known value.
    for (int a = 0; a < 16; a++) begin
      idle();
      set_lane(a % N, 1'b1, 4'hF, 10'(a), $urandom, 8'h0);
      next();
    end

    // Partial write then read back on lane 1.
    rsp_ready = 1'b1;
    idle(); set_lane(1, 1'b1, 4'hF, 10'd5, 32'hAABBCCDD, 8'h0); next();
    idle(); set_lane(1, 1'b1, 4'b0101, 10'd5, 32'h11223344, 8'h0); next();
    idle(); set_lane(1, 1'b0, 4'h0, 10'd5, 32'h0, 8'h3C);
    sample(); chk("rd_grant_l1", req_ready, 4'b0010);
    next(); idle();
    sample(); chk("rd_lat_c1", rsp_valid, 1'b0);
    next();
    sample();
    chk("rd_lat_c2", rsp_valid, 1'b1);
    chk("rd_data_lit", rsp_data, 32'hAA22CC44);
    chk("rd_tag_lit", rsp_tag, 8'h3C);
    chk("rd_lane_lit", rsp_lane, 2'd1);
    next();

    // Lane 3 handshake (byteen=0 no-op write), then all lanes read.
    idle(); set_lane(3, 1'b1, 4'h0, 10'd0, 32'h0, 8'h0); next();
    idle();
    for (int i = 0; i < N; i++) set_lane(i, 1'b0, 4'h0, 10'(i), 32'h0, 8'(i));
    pending = 4'hF; n = 0;
    for (int c = 0; c < 30 && pending != 0; c++) begin
      sample();
      gr = req_ready;
      for (int i = 0; i < N; i++) if (gr[i] && n < 4) begin order[n] = i; n++; end
      next();
      req_valid = req_valid & ~gr;
      pending = pending & ~gr;
    end
    chk("rr_count", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), order[i], i);
    idle();
    repeat (6) next();

    // Backpressure: only RD reads accepted, writes still flow at zero credit.
    rsp_ready = 1'b0;
    set_lane(0, 1'b0, 4'h0, 10'd7, 32'h0, 8'h50);
    acc = 0;
    for (int c = 0; c < 8; c++) begin sample(); if (req_ready[0]) acc++; next(); end
    chk("credit_accepts", acc, RD);
    set_lane(2, 1'b1, 4'hF, 10'd9, 32'hCAFEF00D, 8'h0);
    wcnt = 0;
    for (int c = 0; c < 4; c++) begin sample(); if (req_ready == 4'b0100) wcnt++; next(); end
    chk("wr_at_zero_credit", wcnt, 4);
    req_valid[2] = 1'b0;
    rsp_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin sample(); if (req_ready[0]) acc++; next(); end
    chk("lane0_resumes", acc > 0, 1'b1);
    idle();
    repeat (6) next();

    // Reset in the middle of a burst with queued responses.
    rsp_ready = 1'b0;
    set_lane(0, 1'b0, 4'h0, 10'd3, 32'h0, 8'h77);
    repeat (4) next();
    sample(); chk("pre_rst_valid", rsp_valid, 1'b1);
    reset_n = 1'b0;
    #1 chk("rst_drops_valid", rsp_valid, 1'b0);
    next(); next();
    reset_n = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin sample(); if (req_ready[0]) acc++; next(); end
    chk("credits_restored", acc, RD);
    idle(); rsp_ready = 1'b1;
    repeat (6) next();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      idle();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 40)
          set_lane(i, 1'($urandom_range(0, 1)), 4'($urandom), 10'($urandom_range(0, 15)),
                   $urandom, 8'($urandom));
      rsp_ready = ($urandom_range(0, 99) < 60);
      next();
    end
    idle(); rsp_ready = 1'b1;
    repeat (10) next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
